// File: rtl/udp_pkg.sv
// Shared definitions for the UDP transmit arbiter: FSM encoding and payload limits.
package udp_pkg;

  localparam int UDP_MAX_PAYLOAD = 1472;
  localparam int BYTE_NUM_W      = 16;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    START,
    WAIT_DONE,
    GAP
  } arb_state_e;

endpackage

// File: rtl/udp_tx_arbiter_if.sv
// Requester and engine signals of the UDP transmit arbiter; master = arbiter, slave = sources/engine.
interface udp_tx_arbiter_if #(
  parameter int NREQ = 2
);
  import udp_pkg::*;

  logic [NREQ-1:0]            req;
  logic [NREQ*BYTE_NUM_W-1:0] req_byte_num;
  logic [NREQ*BYTE_NUM_W-1:0] req_des_port;
  logic [NREQ*32-1:0]         req_data;
  logic [NREQ-1:0]            grant;
  logic [NREQ-1:0]            data_req;
  logic [NREQ-1:0]            done;
  logic [NREQ-1:0]            rej;
  logic                       tx_start_en;
  logic [BYTE_NUM_W-1:0]      tx_byte_num;
  logic [BYTE_NUM_W-1:0]      des_port;
  logic [31:0]                tx_data;
  logic                       tx_req;
  logic                       tx_done;
  logic                       busy;

  modport master (
    input  req, req_byte_num, req_des_port, req_data, tx_req, tx_done,
    output grant, data_req, done, rej, tx_start_en, tx_byte_num, des_port, tx_data, busy
  );

  modport slave (
    output req, req_byte_num, req_des_port, req_data, tx_req, tx_done,
    input  grant, data_req, done, rej, tx_start_en, tx_byte_num, des_port, tx_data, busy
  );

endinterface

// File: rtl/udp_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin select; first asserted request after last_i, wrapping.
module rr_pick #(
  parameter  int NREQ = 2,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   last_i,
  output logic [NREQ-1:0] winner_o,
  output logic            valid_o
);

  logic hi_hit;
  logic lo_hit;

  // NOTE: every output gets a default first, so no path through this block infers a latch.
  always_comb begin
    winner_o = '0;
    hi_hit   = 1'b0;
    lo_hit   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!hi_hit && req_i[i] && (i > int'(last_i))) begin
        winner_o[i] = 1'b1;
        hi_hit      = 1'b1;
      end
    end
    // Nothing above last: wrap to the lowest asserted index.
    for (int i = 0; i < NREQ; i++) begin
      if (!hi_hit && !lo_hit && req_i[i]) begin
        winner_o[i] = 1'b1;
        lo_hit      = 1'b1;
      end
    end
    valid_o = hi_hit | lo_hit;
  end

endmodule

// File: rtl/udp_tx_arbiter.sv
// udp_tx_arbiter: shares one UDP tx engine between NREQ sources (round-robin, length check, IFG).
// Optional WAIT_DONE watchdog with timeout_err_o output: define UDP_TX_ARB_TIMEOUT_EN.
module udp_tx_arbiter
  import udp_pkg::*;
#(
  parameter int NREQ           = 2,
  parameter int MAX_BYTES      = UDP_MAX_PAYLOAD,
  parameter int IFG_CYCLES     = 12,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic             clk,
  input  logic             rst,
`ifdef UDP_TX_ARB_TIMEOUT_EN
  output logic             timeout_err_o,
`endif
  udp_tx_arbiter_if.master bus
);

  localparam int                    IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [15:0]           GAP_LAST = 16'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);
  localparam logic [BYTE_NUM_W-1:0] MAX_LEN  = BYTE_NUM_W'(MAX_BYTES);

  arb_state_e            state_q, state_d;
  logic [NREQ-1:0]       grant_q, grant_d;
  logic [NREQ-1:0]       done_q, done_d;
  logic [NREQ-1:0]       rej_q, rej_d;
  logic                  start_q, start_d;
  logic [BYTE_NUM_W-1:0] len_q, len_d;
  logic [BYTE_NUM_W-1:0] port_q, port_d;
  logic [IW-1:0]         last_q, last_d;
  logic [15:0]           gap_q, gap_d;
`ifdef UDP_TX_ARB_TIMEOUT_EN
  logic [15:0]           wd_q, wd_d;
  logic                  terr_q, terr_d;
`endif

  logic [NREQ-1:0]       pick_oh;
  logic                  pick_valid;
  logic [IW-1:0]         pick_idx;
  logic [BYTE_NUM_W-1:0] pick_len;
  logic [BYTE_NUM_W-1:0] pick_port;
  logic [31:0]           tx_data_mux;

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req_i    (bus.req),
    .last_i   (last_q),
    .winner_o (pick_oh),
    .valid_o  (pick_valid)
  );

  always_comb begin
    pick_idx  = '0;
    pick_len  = '0;
    pick_port = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_oh[i]) begin
        pick_idx  = IW'(i);
        pick_len  = bus.req_byte_num[BYTE_NUM_W*i +: BYTE_NUM_W];
        pick_port = bus.req_des_port[BYTE_NUM_W*i +: BYTE_NUM_W];
      end
    end
  end

  always_comb begin
    tx_data_mux = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) tx_data_mux = bus.req_data[32*i +: 32];
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = '0;
    rej_d   = '0;
    start_d = 1'b0;
    len_d   = len_q;
    port_d  = port_q;
    last_d  = last_q;
    gap_d   = gap_q;
`ifdef UDP_TX_ARB_TIMEOUT_EN
    wd_d    = wd_q;
    terr_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick_oh;
          len_d   = pick_len;
          port_d  = pick_port;
          last_d  = pick_idx;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if ((len_q == '0) || (len_q > MAX_LEN)) begin
          rej_d   = grant_q;
          grant_d = '0;
          gap_d   = '0;
          state_d = GAP;
        end else begin
          start_d = 1'b1;
          state_d = START;
        end
      end
      START: begin
`ifdef UDP_TX_ARB_TIMEOUT_EN
        wd_d    = '0;
`endif
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (bus.tx_done) begin
          done_d  = grant_q;
          grant_d = '0;
          gap_d   = '0;
          state_d = GAP;
        end
`ifdef UDP_TX_ARB_TIMEOUT_EN
        else if (wd_q == 16'(TIMEOUT_CYCLES - 1)) begin
          terr_d  = 1'b1;
          rej_d   = grant_q;
          grant_d = '0;
          gap_d   = '0;
          state_d = GAP;
        end else begin
          wd_d = wd_q + 16'd1;
        end
`endif
      end
      GAP: begin
        // The gap always lasts at least one cycle, even with IFG_CYCLES = 0.
        if (gap_q >= GAP_LAST) state_d = IDLE;
        else                   gap_d   = gap_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      done_q  <= '0;
      rej_q   <= '0;
      start_q <= 1'b0;
      len_q   <= '0;
      port_q  <= '0;
      last_q  <= IW'(NREQ - 1);
      gap_q   <= '0;
`ifdef UDP_TX_ARB_TIMEOUT_EN
      wd_q    <= '0;
      terr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      rej_q   <= rej_d;
      start_q <= start_d;
      len_q   <= len_d;
      port_q  <= port_d;
      last_q  <= last_d;
      gap_q   <= gap_d;
`ifdef UDP_TX_ARB_TIMEOUT_EN
      wd_q    <= wd_d;
      terr_q  <= terr_d;
`endif
    end
  end

  assign bus.grant       = grant_q;
  assign bus.done        = done_q;
  assign bus.rej         = rej_q;
  assign bus.tx_start_en = start_q;
  assign bus.tx_byte_num = len_q;
  assign bus.des_port    = port_q;
  assign bus.tx_data     = tx_data_mux;
  assign bus.busy        = (state_q != IDLE);
  assign bus.data_req    = ((state_q == WAIT_DONE) && bus.tx_req) ? grant_q : '0;
`ifdef UDP_TX_ARB_TIMEOUT_EN
  assign timeout_err_o   = terr_q;
`endif

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Randomized bench for udp_tx_arbiter against a transaction-level model of arbitration and timing.
module tb_udp_tx_arbiter;

  localparam int NREQ = 2;
  localparam int IFG  = 12;
  localparam int TMO  = 100;
  localparam int MAXB = 1472;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  udp_tx_arbiter_if #(.NREQ(NREQ)) bus ();
`ifdef UDP_TX_ARB_TIMEOUT_EN
  logic timeout_err;
`endif

  udp_tx_arbiter #(
    .NREQ(NREQ), .MAX_BYTES(MAXB), .IFG_CYCLES(IFG), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
`ifdef UDP_TX_ARB_TIMEOUT_EN
    .timeout_err_o (timeout_err),
`endif
    .bus           (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          m_last;
  int          src_len [NREQ];
  bit          rand_data;
  bit          rereq;
  bit          auto_req;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rand_len();
    case ($urandom_range(7, 0))
      0:       return 0;
      1:       return MAXB;
      2:       return MAXB + 1;
      default: return $urandom_range(MAXB, 1);
    endcase
  endfunction

  task automatic set_src(input int i, input int len, input logic [15:0] port);
    src_len[i]                    = len;
    bus.req[i]                    = 1'b1;
    bus.req_byte_num[16*i +: 16]  = 16'(len);
    bus.req_des_port[16*i +: 16]  = port;
  endtask

  task automatic refresh(input int skip);
    for (int i = 0; i < NREQ; i++)
      if (i != skip && !bus.req[i] && $urandom_range(1, 0) == 1)
        set_src(i, rand_len(), 16'($urandom));
  endtask

  task automatic drive_noise();
    if (rand_data)
      for (int i = 0; i < NREQ; i++) bus.req_data[32*i +: 32] = $urandom;
  endtask

  // Round-robin rule: first requesting index after the last winner, wrapping.
  function automatic int model_pick();
    int j;
    for (int k = 1; k <= NREQ; k++) begin
      j = (m_last + k) % NREQ;
      if (bus.req[j]) return j;
    end
    return -1;
  endfunction

  // Called on the first GAP cycle; checks the remaining gap and the return to IDLE.
  task automatic gap_tail(input int exp_len);
    for (int g = 2; g <= IFG; g++) begin
      @(negedge clk);
      bus.tx_req  = 1'($urandom);
      bus.tx_done = 1'($urandom);
      drive_noise();
      #1;
      check("gap_busy", bus.busy, 1);
      check("gap_grant", bus.grant, 0);
      check("gap_data_req", bus.data_req, 0);
      check("gap_done", bus.done, 0);
      check("gap_tx_data", bus.tx_data, 0);
      check("gap_len_hold", bus.tx_byte_num, exp_len);
    end
    @(negedge clk);
    bus.tx_req  = 1'b0;
    bus.tx_done = 1'b0;
    #1;
    check("idle_busy", bus.busy, 0);
    check("idle_done", bus.done, 0);
  endtask

  // Entered on a negedge with the DUT in IDLE and requests already driven.
  task automatic run_packet();
    int w;
    int len;
    int k;
    bit ok;
    w = model_pick();
    if (w < 0) begin
      check("model_has_req", 0, 1);
      return;
    end
    m_last = w;
    len    = src_len[w];
    ok     = (len >= 1) && (len <= MAXB);

    @(negedge clk);
    bus.tx_req = 1'($urandom);
    #1;
    check("chk_grant", bus.grant, 1 << w);
    check("chk_busy", bus.busy, 1);
    check("chk_len", bus.tx_byte_num, len);
    check("chk_port", bus.des_port, bus.req_des_port[16*w +: 16]);
    check("chk_no_start", bus.tx_start_en, 0);
    check("chk_data_req", bus.data_req, 0);

    @(negedge clk);
    bus.tx_req = 1'($urandom);
    #1;
    if (!ok) begin
      check("rej_pulse", bus.rej, 1 << w);
      check("rej_grant", bus.grant, 0);
      check("rej_no_start", bus.tx_start_en, 0);
      check("rej_no_done", bus.done, 0);
      bus.req[w] = 1'b0;
      if (auto_req) refresh(w);
      gap_tail(len);
      return;
    end
    check("start_en", bus.tx_start_en, 1);
    check("start_no_rej", bus.rej, 0);
    check("start_data_req", bus.data_req, 0);
    if (!rereq && $urandom_range(3, 0) == 0) bus.req[w] = 1'b0;

    k = $urandom_range(6, 1);
    for (int c = 0; c < k; c++) begin
      @(negedge clk);
      bus.tx_req = 1'($urandom);
      drive_noise();
      #1;
      check("wait_data_req", bus.data_req, bus.tx_req ? (1 << w) : 0);
      check("wait_tx_data", bus.tx_data, bus.req_data[32*w +: 32]);
      check("wait_grant", bus.grant, 1 << w);
      if (c == 0) check("start_one_cycle", bus.tx_start_en, 0);
    end

    @(negedge clk);
    bus.tx_req  = 1'b0;
    bus.tx_done = 1'b1;
    if (auto_req) refresh(w);
    #1;
    check("done_not_early", bus.done, 0);

    @(negedge clk);
    bus.tx_done = 1'b0;
    #1;
    check("done_pulse", bus.done, 1 << w);
    check("done_grant", bus.grant, 0);
    check("done_busy", bus.busy, 1);
    check("done_no_rej", bus.rej, 0);
    if (!rereq) bus.req[w] = 1'b0;
    gap_tail(len);
  endtask

  initial begin
    int i;
    rst              = 1'b1;
    bus.req          = '0;
    bus.req_byte_num = '0;
    bus.req_des_port = '0;
    bus.req_data     = '0;
    bus.tx_req       = 1'b0;
    bus.tx_done      = 1'b0;
    rand_data        = 1'b1;
    rereq            = 1'b0;
    auto_req         = 1'b0;
    m_last           = NREQ - 1;
    for (int s = 0; s < NREQ; s++) src_len[s] = 0;

    repeat (3) @(negedge clk);
    drive_noise();
    #1;
    check("rst_grant", bus.grant, 0);
    check("rst_data_req", bus.data_req, 0);
    check("rst_done", bus.done, 0);
    check("rst_rej", bus.rej, 0);
    check("rst_start", bus.tx_start_en, 0);
    check("rst_len", bus.tx_byte_num, 0);
    check("rst_port", bus.des_port, 0);
    check("rst_tx_data", bus.tx_data, 0);
    check("rst_busy", bus.busy, 0);
`ifdef UDP_TX_ARB_TIMEOUT_EN
    check("rst_timeout", timeout_err, 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // Single request.
    set_src(0, 64, 16'h1F90);
    run_packet();

    // Both sources held continuously: grants alternate.
    rereq = 1'b1;
    set_src(0, 100, 16'h0100);
    set_src(1, 200, 16'h0200);
    repeat (4) run_packet();
    rereq   = 1'b0;
    bus.req = '0;

    // Length limits.
    set_src(0, 0, 16'h0001);
    run_packet();
    set_src(1, MAXB + 1, 16'h0002);
    run_packet();
    set_src(0, MAXB, 16'h0003);
    run_packet();

    // Fixed payload word on source 1.
    rand_data = 1'b0;
    bus.req_data[31:0]  = 32'h0;
    bus.req_data[63:32] = 32'hDEADBEEF;
    set_src(1, 512, 16'h4444);
    run_packet();
    rand_data = 1'b1;

    // Reset while the engine owns a packet.
    set_src(0, 200, 16'h1234);
    repeat (3) @(negedge clk);
    bus.tx_req = 1'b1;
    #1;
    check("mid_data_req", bus.data_req, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_grant", bus.grant, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_data_req", bus.data_req, 0);
    check("mid_rst_len", bus.tx_byte_num, 0);
    bus.tx_done = 1'b1;
    bus.req     = '0;
    m_last      = NREQ - 1;
    @(negedge clk);
    #1;
    check("mid_rst_done", bus.done, 0);
    check("mid_rst_rej", bus.rej, 0);
    rst         = 1'b0;
    bus.tx_done = 1'b0;
    bus.tx_req  = 1'b0;
    @(negedge clk);
    #1;
    check("post_rst_done", bus.done, 0);
    check("post_rst_busy", bus.busy, 0);
    set_src(1, 300, 16'h5555);
    run_packet();

`ifdef UDP_TX_ARB_TIMEOUT_EN
    // Engine never finishes: watchdog rejects, then the other source is served.
    bus.req = '0;
    set_src(0, 300, 16'h7777);
    set_src(1, 40, 16'h8888);
    i = model_pick();
    m_last = i;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("tmo_start", bus.tx_start_en, 1);
    for (int c = 1; c <= TMO; c++) begin
      @(negedge clk);
      bus.tx_req = 1'($urandom);
      #1;
      check("tmo_quiet", timeout_err, 0);
    end
    @(negedge clk);
    bus.tx_req = 1'b0;
    #1;
    check("tmo_err", timeout_err, 1);
    check("tmo_rej", bus.rej, 1 << i);
    check("tmo_grant", bus.grant, 0);
    check("tmo_no_done", bus.done, 0);
    bus.req[i] = 1'b0;
    gap_tail(300);
    run_packet();
`endif

    // Random traffic.
    auto_req = 1'b1;
    repeat (40) begin
      if (bus.req == '0) begin
        i = $urandom_range(NREQ - 1, 0);
        set_src(i, rand_len(), 16'($urandom));
      end
      run_packet();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/udp_tx_arbiter.md
Name: udp_tx_arbiter

Overview:
- Shares the single UDP transmit engine (GMII tx clock domain) between NREQ independent packet sources.
- Picks a winner by round-robin and latches that source's byte count and destination port.
- Pulses the engine's start strobe, routes the engine's data-request strobe and the source's data words, then waits for the engine's done strobe.
- Enforces an inter-packet idle gap before granting the next source.

Parameters:
- NREQ, 2, number of requesters (2..8).
- MAX_BYTES, 1472, largest legal UDP payload in bytes.
- IFG_CYCLES, 12, idle clk cycles after tx_done before the next arbitration (0 allowed).
- TIMEOUT_CYCLES, 65535, watchdog limit in WAIT_DONE (used only with the optional feature).

Ports:
- clk  in  1  GMII transmit clock.
- rst  in  1  asynchronous reset, active-high.
- req  in  NREQ  per-source request; held high until that source's done/rej pulse.
- req_byte_num  in  NREQ*16  per-source payload length; slice i = [16i+15:16i].
- req_des_port  in  NREQ*16  per-source destination UDP port.
- req_data  in  NREQ*32  per-source payload word, valid when data_req[i] pulses.
- grant  out  NREQ  one-hot; the current owner of the engine.
- data_req  out  NREQ  engine data-request routed to the granted source.
- done  out  NREQ  one-cycle pulse when the granted packet is complete.
- rej  out  NREQ  one-cycle pulse when a request is rejected for an illegal length.
- tx_start_en  out  1  one-cycle start strobe to the engine.
- tx_byte_num  out  16  latched payload length to the engine.
- des_port  out  16  latched destination port to the engine.
- tx_data  out  32  granted source's req_data (combinational mux on grant; 0 when no grant).
- tx_req  in  1  engine data-request strobe.
- tx_done  in  1  engine packet-complete strobe.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: all outputs 0, state IDLE, round-robin pointer last = NREQ-1, gap counter 0.
- IDLE:
  - If any req is high, pick the first asserted index searching from last+1 modulo NREQ.
  - Set grant to that index, latch its byte_num and des_port, set last to the index, go to CHECK.
- CHECK (one cycle):
  - If the latched length is 0 or greater than MAX_BYTES: pulse rej[i], clear grant, go to GAP. No tx_start_en is issued.
  - Otherwise go to START.
- START (one cycle): tx_start_en = 1, then go to WAIT_DONE. tx_start_en therefore rises 2 cycles after req is first sampled in IDLE.
- WAIT_DONE:
  - data_req[i] = tx_req & grant[i]. Every other data_req bit is 0.
  - On tx_done: pulse done[i] in the next cycle, clear grant, go to GAP.
- GAP: count IFG_CYCLES cycles, then go to IDLE. If IFG_CYCLES = 0, go to IDLE after one cycle.
- tx_byte_num and des_port hold from CHECK until the next latch. They are not cleared.
- A req that deasserts after grant is ignored; the packet runs to completion and done still pulses.
- A tx_req arriving outside WAIT_DONE is ignored. A tx_done arriving outside WAIT_DONE is ignored.
- tx_done together with a new req in the same cycle: the new req waits for GAP to expire.
- Fairness: with all sources requesting continuously, grants rotate 0,1,...,NREQ-1,0.
- A rejected source also advances last.
- rst asserted mid-packet returns the block to IDLE immediately.
  - No done or rej pulse is produced.
  - The engine is reset by the same system reset.

Optional Feature:
- Macro UDP_TX_ARB_TIMEOUT_EN.
- When defined:
  - A 16-bit watchdog counts in WAIT_DONE and is cleared on entry.
  - On reaching TIMEOUT_CYCLES with no tx_done, pulse a new output timeout_err (1 bit) and rej[i], clear grant, and go to GAP.
  - A later stray tx_done is ignored.
- When undefined: the timeout_err port and the counter are absent, and WAIT_DONE waits indefinitely.

Decomposition:
- Shared package udp_pkg:
  - state encoding constants IDLE, CHECK, START, WAIT_DONE, GAP.
  - UDP_MAX_PAYLOAD = 1472.
  - width constant BYTE_NUM_W = 16.
- Sub-module rr_pick: combinational round-robin priority select.
  - Inputs: req vector and last index.
  - Outputs: one-hot winner and valid.
  - Reusable by a future receive-side distributor.

Test Plan:
- Single request: NREQ=2, req=01, len 64, port 0x1F90.
  - tx_start_en pulses 2 cycles after req.
  - tx_byte_num=64, des_port=0x1F90.
  - tx_done → done=01 the next cycle.
  - busy drops after 12 gap cycles.
- Round-robin: req=11 held continuously.
  - Grant order is 01,10,01,10 over four packets.
  - Each tx_start_en is spaced at least 12 cycles after the previous tx_done.
- Illegal lengths:
  - len 0 → rej pulses, no tx_start_en.
  - len 1473 → rej.
  - len 1472 → accepted.
- Data routing: source 1 granted, req_data slice 1 = 0xDEADBEEF.
  - Each tx_req pulse appears only on data_req[1].
  - tx_data = 0xDEADBEEF.
- Reset mid-packet: rst in WAIT_DONE.
  - grant=0, busy=0, no done pulse.
  - A new req after release is served normally.
- Timeout (with macro): TIMEOUT_CYCLES=100, tx_done withheld.
  - timeout_err and rej pulse at cycle 100 of WAIT_DONE.
  - The next requester is granted after the gap.
